// File: rtl/dcfeb_arb_pkg.sv
// Shared types and constants for the DCFEB packet arbiter.
package dcfeb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    FLUSH = 2'd2,
    GAP   = 2'd3
  } arb_state_e;

  localparam logic [15:0] ABORT_WORD = 16'hDEAD;
  localparam int          STARVE_W   = 10;
  localparam int          STARVE_MAX = (1 << STARVE_W) - 1;

endpackage

// File: rtl/dcfeb_pkt_arbiter_rr_pick.sv
// Round-robin picker: first requester strictly after the pointer, wrapping mod NCH.
module rr_pick #(
  parameter int NCH = 7
) (
  input  logic [NCH-1:0] req,
  input  logic [2:0]     pointer,
  output logic [2:0]     grant,
  output logic           found
);

  always_comb begin
    grant = '0;
    found = 1'b0;
    // Scan farthest-first so the nearest candidate after the pointer overwrites last.
    for (int k = NCH - 1; k >= 0; k--) begin
      logic [3:0] idx;
      idx = 4'(pointer) + 4'd1 + 4'(k);
      if (idx >= 4'(NCH)) idx = idx - 4'(NCH);
      if (req[idx[2:0]]) begin
        grant = idx[2:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcfeb_pkt_arbiter.sv
// Packet-atomic round-robin drain of the DCFEB receive FIFOs onto one 16-bit stream.
// Optional per-channel statistics ports are enabled by defining DCFEB_ARB_STATS_EN.
module dcfeb_pkt_arbiter
  import dcfeb_arb_pkg::*;
#(
  parameter int NCH     = 7,
  parameter int TIMEOUT = 1023,
  parameter int GAP_CYC = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NCH-1:0]    PKT_RDY,
  input  logic [NCH-1:0]    FF_EMPTY,
  input  logic [16*NCH-1:0] FF_DATA,
  input  logic [NCH-1:0]    FF_LAST,
  output logic [NCH-1:0]    FF_REN,
  input  logic              OUT_BUSY,
  output logic [15:0]       OUT_DATA,
  output logic              OUT_VALID,
  output logic              OUT_LAST,
  output logic              OUT_ABORT,
  output logic [2:0]        OUT_CH,
  output logic              ACTIVE
`ifdef DCFEB_ARB_STATS_EN
  ,
  output logic [16*NCH-1:0] PKT_CNT,
  output logic [8*NCH-1:0]  ABORT_CNT
`endif
);

  if (TIMEOUT < 1 || TIMEOUT > STARVE_MAX) begin : g_bad_timeout
    $error("dcfeb_pkt_arbiter: TIMEOUT must be in 1..1023");
  end
  if (NCH < 1 || NCH > 8) begin : g_bad_nch
    $error("dcfeb_pkt_arbiter: NCH must be in 1..8");
  end

  localparam logic [STARVE_W-1:0] TO_VAL  = STARVE_W'(TIMEOUT);
  localparam logic [STARVE_W-1:0] GAP_END = STARVE_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam arb_state_e          DONE_ST = (GAP_CYC > 0) ? GAP : IDLE;

  arb_state_e          state, state_nx;
  logic [2:0]          ptr;
  logic [2:0]          pick_g;
  logic                pick_found;
  logic [STARVE_W-1:0] starve;
  logic [STARVE_W-1:0] gap_cnt;
  logic                rd;
  logic                abort_fire;

  logic        cur_empty, cur_last, timed_out;
  logic [15:0] cur_data;

  // ptr doubles as the latched grant for the packet in flight.
  assign cur_empty = FF_EMPTY[ptr];
  assign cur_last  = FF_LAST[ptr];
  assign cur_data  = FF_DATA[{ptr, 4'd0} +: 16];
  assign timed_out = (starve == TO_VAL);
  assign ACTIVE    = (state == XFER) || (state == FLUSH);

  rr_pick #(.NCH(NCH)) u_pick (
    .req     (PKT_RDY),
    .pointer (ptr),
    .grant   (pick_g),
    .found   (pick_found)
  );

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    // NOTE: defaults first; any path that skips an assignment would otherwise infer a latch.
    state_nx   = state;
    rd         = 1'b0;
    abort_fire = 1'b0;
    unique case (state)
      IDLE:  if (pick_found) state_nx = XFER;
      XFER: begin
        if (timed_out) begin
          abort_fire = !OUT_BUSY;
          if (abort_fire) state_nx = FLUSH;
        end else begin
          rd = !cur_empty && !OUT_BUSY;
          if (rd && cur_last) state_nx = DONE_ST;
        end
      end
      FLUSH: begin
        rd = !cur_empty;
        if (rd && cur_last) state_nx = DONE_ST;
      end
      GAP:   if (gap_cnt == GAP_END) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (RST) rd = 1'b0;
    FF_REN = NCH'(rd) << ptr;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr       <= 3'(NCH - 1);
      OUT_CH    <= '0;
      OUT_DATA  <= '0;
      OUT_VALID <= 1'b0;
      OUT_LAST  <= 1'b0;
      OUT_ABORT <= 1'b0;
      starve    <= '0;
      gap_cnt   <= '0;
    end else begin
      OUT_VALID <= 1'b0;
      OUT_LAST  <= 1'b0;
      OUT_ABORT <= 1'b0;
      gap_cnt   <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (state == IDLE && pick_found) begin
        ptr    <= pick_g;
        OUT_CH <= pick_g;
        starve <= '0;
      end
      if (state == XFER) begin
        if (rd) begin
          OUT_VALID <= 1'b1;
          OUT_DATA  <= cur_data;
          OUT_LAST  <= cur_last;
          starve    <= '0;
        end else if (abort_fire) begin
          OUT_VALID <= 1'b1;
          OUT_DATA  <= ABORT_WORD;
          OUT_LAST  <= 1'b1;
          OUT_ABORT <= 1'b1;
        end else if (!timed_out) begin
          // Backpressure is not starvation; once at TIMEOUT the count holds for the abort.
          if (OUT_BUSY)       starve <= '0;
          else if (cur_empty) starve <= starve + 1'b1;
        end
      end
    end
  end

`ifdef DCFEB_ARB_STATS_EN
  logic [15:0] pkt_cnt   [NCH];
  logic [7:0]  abort_cnt [NCH];

  always_ff @(posedge CLK) begin
    // NOTE: these counter arrays are architecturally visible, so every entry is cleared on reset.
    if (RST) begin
      for (int i = 0; i < NCH; i++) begin
        pkt_cnt[i]   <= '0;
        abort_cnt[i] <= '0;
      end
    end else begin
      if (state == XFER && rd && cur_last && pkt_cnt[ptr] != '1)
        pkt_cnt[ptr] <= pkt_cnt[ptr] + 1'b1;
      if (abort_fire && abort_cnt[ptr] != '1)
        abort_cnt[ptr] <= abort_cnt[ptr] + 1'b1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_stats
    assign PKT_CNT[16*i +: 16]  = pkt_cnt[i];
    assign ABORT_CNT[8*i +: 8]  = abort_cnt[i];
  end
`endif

endmodule
